// File: rtl/pmu_clock_scheduler_pkg.sv
// Shared types for the PMU clock scheduler: channel mode encoding, change-FSM
// state enum and a width helper used for index/counter sizing.
package pmu_clock_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_FULL = 2'd1,
    MODE_DIV  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REJECT = 2'd2
  } chg_state_t;

  // Bits needed to index v items (or hold 0..v-1), never less than 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pmu_clock_scheduler_if.sv
// Control bus of the PMU clock scheduler: mode-change req/ack handshake and
// the divider reload write port.
//   master: drives change_req/ch/mode/sel and div_wr/idx/val, sees ack/err
//   slave : the scheduler side
interface pmu_clock_scheduler_if #(
  parameter int N_CH  = 3,
  parameter int N_DIV = 3,
  parameter int DIV_W = 21
);
  import pmu_clock_scheduler_pkg::*;

  localparam int CW = clog2_min1(N_CH);
  localparam int SW = clog2_min1(N_DIV);

  logic             change_req;
  logic [CW-1:0]    change_ch;
  logic [1:0]       change_mode;
  logic [SW-1:0]    change_sel;
  logic             change_ack;
  logic             change_err;
  logic             div_wr;
  logic [SW-1:0]    div_idx;
  logic [DIV_W-1:0] div_val;

  modport master (
    output change_req, change_ch, change_mode, change_sel, div_wr, div_idx, div_val,
    input  change_ack, change_err
  );

  modport slave (
    input  change_req, change_ch, change_mode, change_sel, div_wr, div_idx, div_val,
    output change_ack, change_err
  );

endinterface

// File: rtl/pmu_clock_scheduler_divider.sv
// pmu_divider: reloadable count-down divider.
//   clk, reset : system clock, synchronous active-high reset (loads INIT)
//   wr, val    : load val into both reload and counter this cycle
//   tick       : high for the one cycle the counter sits at 0 (period reload+1)
module pmu_divider #(
  parameter int               DIV_W = 21,
  parameter logic [DIV_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [DIV_W-1:0] val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] reload_q;

  // A write restarts the count, so it suppresses an expiry in the same cycle.
  assign tick = (cnt_q == '0) && !wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= INIT;
      reload_q <= INIT;
    end else if (wr) begin
      cnt_q    <= val;
      reload_q <= val;
    end else if (cnt_q == '0) begin
      cnt_q <= reload_q;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/pmu_clock_scheduler.sv
// pmu_clock_scheduler: per-channel clock enables / square clocks from shared
// dividers, glitch-safe mode changes over a req/ack handshake, wake timer.
//   clk, reset   : system clock, synchronous active-high reset
//   bus (slave)  : change req/ch/mode/sel -> ack/err; div_wr/idx/val reload port
//   ch_clk       : registered channel square clocks
//   ch_stb       : 1-cycle strobe coincident with each ch_clk rising value
//   timer_tick   : 1-cycle pulse every (PRESCALE+1)*(TIMER_RELOAD+1) cycles
module pmu_clock_scheduler
  import pmu_clock_scheduler_pkg::*;
#(
  parameter int                                 N_CH         = 3,
  parameter int                                 N_DIV        = 3,
  parameter int                                 DIV_W        = 21,
  parameter logic [N_DIV*DIV_W-1:0]             DIV_INIT     = {21'h10, 21'h5000, 21'h16e360},
  parameter logic [2*N_CH-1:0]                  MODE_INIT    = {2'd0, 2'd1, 2'd2},
  parameter logic [N_CH*clog2_min1(N_DIV)-1:0]  SEL_INIT     = '0,
  parameter int                                 PRESCALE     = 12000000,
  parameter int                                 TIMER_RELOAD = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  pmu_clock_scheduler_if.slave bus,
  output logic [N_CH-1:0]      ch_clk,
  output logic [N_CH-1:0]      ch_stb,
  output logic                 timer_tick
);

  localparam int CW    = clog2_min1(N_CH);
  localparam int SW    = clog2_min1(N_DIV);
  localparam int CH_P  = 1 << CW;
  localparam int DIV_P = 1 << SW;
  localparam int PW    = clog2_min1(PRESCALE + 1);
  localparam int TW    = clog2_min1(TIMER_RELOAD + 1);

  typedef struct packed {
    logic [CW-1:0] ch;
    mode_t         mode;
    logic [SW-1:0] sel;
  } chg_req_t;

  // ---------------- shared dividers ----------------
  logic [N_DIV-1:0] div_tick;
  logic [DIV_P-1:0] div_tick_ext;

  for (genvar k = 0; k < N_DIV; k++) begin : g_div
    pmu_divider #(
      .DIV_W (DIV_W),
      .INIT  (DIV_INIT[k*DIV_W +: DIV_W])
    ) u_div (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.div_wr && (bus.div_idx == SW'(k))),
      .val   (bus.div_val),
      .tick  (div_tick[k])
    );
  end

  // Zero-padded so any SW-bit select value is a legal index.
  assign div_tick_ext = DIV_P'(div_tick);

  // ---------------- change FSM ----------------
  chg_state_t     state_q, state_d;
  chg_req_t       pend_q;
  logic           req_ok;
  logic           apply;
  logic [CH_P-1:0] ch_clk_ext;

  assign ch_clk_ext = CH_P'(ch_clk);

  assign req_ok = (int'(bus.change_ch) < N_CH) &&
                  (bus.change_mode != MODE_RSVD) &&
                  !((bus.change_mode == MODE_DIV) && (int'(bus.change_sel) >= N_DIV));

  // Switch only while the target clock is low; the channel is frozen for
  // that cycle so it cannot rise under the old mode at the boundary.
  assign apply = !reset && (state_q == ST_WAIT) && !ch_clk_ext[pend_q.ch];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else if ((state_q == ST_IDLE) && bus.change_req && req_ok) begin
      pend_q.ch   <= bus.change_ch;
      pend_q.mode <= mode_t'(bus.change_mode);
      pend_q.sel  <= bus.change_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.change_req) state_d = req_ok ? ST_WAIT : ST_REJECT;
      ST_WAIT:   if (apply) state_d = ST_IDLE;
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.change_ack = 1'b0;
    bus.change_err = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_WAIT:   bus.change_ack = apply;
        ST_REJECT: begin
          bus.change_ack = 1'b1;
          bus.change_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- channels ----------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mode_t         mode_q;
    logic [SW-1:0] sel_q;
    logic          clk_q;
    logic          stb_q;
    logic          hit;
    logic          tog;

    assign hit = apply && (pend_q.ch == CW'(i));
    assign tog = !hit && ((mode_q == MODE_FULL) ||
                          ((mode_q == MODE_DIV) && div_tick_ext[sel_q]));

    always_ff @(posedge clk) begin
      if (reset) begin
        mode_q <= mode_t'(MODE_INIT[2*i +: 2]);
        sel_q  <= SEL_INIT[SW*i +: SW];
        clk_q  <= 1'b0;
        stb_q  <= 1'b0;
      end else begin
        clk_q <= (mode_q == MODE_OFF) ? 1'b0 : (clk_q ^ tog);
        stb_q <= tog && !clk_q;
        if (hit) begin
          mode_q <= pend_q.mode;
          // sel only matters (and is only range-checked) for divider mode
          if (pend_q.mode == MODE_DIV) sel_q <= pend_q.sel;
        end
      end
    end

    assign ch_clk[i] = clk_q;
    assign ch_stb[i] = stb_q;
  end

  // ---------------- wake timer ----------------
  logic [PW-1:0] pre_q;
  logic [TW-1:0] tmr_q;
  logic          step;

  assign step = (pre_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= PW'(PRESCALE);
      tmr_q      <= TW'(TIMER_RELOAD);
      timer_tick <= 1'b0;
    end else begin
      pre_q      <= step ? PW'(PRESCALE) : (pre_q - PW'(1));
      timer_tick <= step && (tmr_q == '0);
      if (step) tmr_q <= (tmr_q == '0) ? TW'(TIMER_RELOAD) : (tmr_q - TW'(1));
    end
  end

endmodule

// File: tb/tb_pmu_clock_scheduler.sv
// Directed bench for pmu_clock_scheduler: div0 reload 3, div1 reload 5,
// div2 reload 7, ch0 DIV/sel0, ch1 FULL, ch2 OFF, PRESCALE 4, TIMER_RELOAD 2.
// k counts rising edges since reset release; outputs are sampled 1 time unit
// after each edge.
module tb_pmu_clock_scheduler;
  import pmu_clock_scheduler_pkg::*;

  localparam int N_CH  = 3;
  localparam int N_DIV = 3;
  localparam int DIV_W = 21;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] ch_clk;
  logic [N_CH-1:0] ch_stb;
  logic            timer_tick;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  bit ch1_full;
  int ch2_phase;
  bit nxt_ack;
  bit nxt_err;

  pmu_clock_scheduler_if #(.N_CH(N_CH), .N_DIV(N_DIV), .DIV_W(DIV_W)) bus ();

  pmu_clock_scheduler #(
    .N_CH         (N_CH),
    .N_DIV        (N_DIV),
    .DIV_W        (DIV_W),
    .DIV_INIT     ({21'd7, 21'd5, 21'd3}),
    .MODE_INIT    ({2'd0, 2'd1, 2'd2}),
    .SEL_INIT     (6'd0),
    .PRESCALE     (4),
    .TIMER_RELOAD (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ch_clk     (ch_clk),
    .ch_stb     (ch_stb),
    .timer_tick (timer_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, want);
    end
  endtask

  // One clock, then compare every output against the hand-derived schedule.
  task automatic step();
    logic [N_CH-1:0] e_clk;
    logic [N_CH-1:0] e_stb;
    @(posedge clk);
    #1;
    k++;
    // ch0: div0 period 4 -> toggles on edges 4,8,12..., rises every 8
    e_clk[0] = ((k / 4) % 2) == 1;
    e_stb[0] = (k % 8) == 4;
    // ch1: full rate, rises on odd edges
    e_clk[1] = ch1_full && ((k % 2) == 1);
    e_stb[1] = e_clk[1];
    case (ch2_phase)
      // div1 (period 6) expires after edges 29,35,41 -> toggles on 30,36,42
      1: begin
        e_clk[2] = (k >= 30) && ((((k - 30) / 6) % 2) == 0);
        e_stb[2] = (k >= 30) && (((k - 30) % 12) == 0);
      end
      // reload 0 written on edge 48 (expiry swallowed), toggles every edge after
      2: begin
        e_clk[2] = (k % 2) == 0;
        e_stb[2] = (k >= 50) && ((k % 2) == 0);
      end
      default: begin
        e_clk[2] = 1'b0;
        e_stb[2] = 1'b0;
      end
    endcase
    chk("ch_clk", 32'(ch_clk), 32'(e_clk));
    chk("ch_stb", 32'(ch_stb), 32'(e_stb));
    chk("timer_tick", 32'(timer_tick), 32'((k > 0) && ((k % 15) == 0)));
    chk("change_ack", 32'(bus.change_ack), 32'(nxt_ack));
    chk("change_err", 32'(bus.change_err), 32'(nxt_err));
    nxt_ack = 1'b0;
    nxt_err = 1'b0;
  endtask

  task automatic drive_req(input int ch, input int mode, input int sel);
    bus.change_req  = 1'b1;
    bus.change_ch   = 2'(ch);
    bus.change_mode = 2'(mode);
    bus.change_sel  = 2'(sel);
  endtask

  initial begin
    reset           = 1'b1;
    bus.change_req  = 1'b0;
    bus.change_ch   = '0;
    bus.change_mode = '0;
    bus.change_sel  = '0;
    bus.div_wr      = 1'b0;
    bus.div_idx     = '0;
    bus.div_val     = '0;
    ch1_full        = 1'b1;
    ch2_phase       = 0;
    nxt_ack         = 1'b0;
    nxt_err         = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_clk", 32'(ch_clk), 32'd0);
    chk("rst_ch_stb", 32'(ch_stb), 32'd0);
    chk("rst_timer", 32'(timer_tick), 32'd0);
    chk("rst_ack", 32'(bus.change_ack), 32'd0);
    reset = 1'b0;
    k     = 0;

    // defaults
    repeat (17) step();

    // ch1 FULL -> OFF requested while ch1 is high; applies next cycle at low
    drive_req(1, MODE_OFF, 0);
    nxt_ack = 1'b1;
    step();                       // k=18
    bus.change_req = 1'b0;
    ch1_full       = 1'b0;
    repeat (2) step();            // k=19,20

    // invalid channel
    drive_req(3, MODE_FULL, 0);
    nxt_ack = 1'b1; nxt_err = 1'b1;
    step();                       // k=21
    bus.change_req = 1'b0;
    step();                       // k=22
    // reserved mode
    drive_req(2, 3, 0);
    nxt_ack = 1'b1; nxt_err = 1'b1;
    step();                       // k=23
    bus.change_req = 1'b0;
    step();                       // k=24
    // divider select out of range
    drive_req(2, MODE_DIV, 3);
    nxt_ack = 1'b1; nxt_err = 1'b1;
    step();                       // k=25
    bus.change_req = 1'b0;
    step();                       // k=26

    // ch2 OFF -> DIV sel1 (clock already low: ack on the WAIT cycle)
    drive_req(2, MODE_DIV, 1);
    nxt_ack = 1'b1;
    step();                       // k=27
    bus.change_req = 1'b0;
    ch2_phase      = 1;
    repeat (20) step();           // k=28..47

    // div1 reload 0 written in its expiry cycle
    bus.div_wr  = 1'b1;
    bus.div_idx = 2'd1;
    bus.div_val = '0;
    ch2_phase   = 2;
    step();                       // k=48
    bus.div_wr = 1'b0;
    repeat (5) step();            // k=49..53

    // ch0 -> FULL while ch0 high: stays in WAIT, then reset hits
    drive_req(0, MODE_FULL, 0);
    step();                       // k=54, no ack yet
    reset = 1'b1;
    #1;
    chk("ack_in_reset", 32'(bus.change_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("wait_rst_ch_clk", 32'(ch_clk), 32'd0);
    chk("wait_rst_ch_stb", 32'(ch_stb), 32'd0);
    chk("wait_rst_timer", 32'(timer_tick), 32'd0);
    chk("wait_rst_ack", 32'(bus.change_ack), 32'd0);
    bus.change_req = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    k         = 0;
    ch1_full  = 1'b1;
    ch2_phase = 0;
    // defaults restored, no late ack, timer restarts
    repeat (31) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
